// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences M-stage loads/stores onto a req/ack data-memory port with a timeout watchdog
//   clk, rst_n                 clock, asynchronous active-low reset
//   MemWriteM, ResultsrcM      store / load (ResultsrcM==2'b01) request from the M stage
//   ByteAddrM                  1 = byte access, 0 = word access
//   ALUResultM, WriteDataM     effective address, store data
//   StallM                     holds the upstream pipeline registers while an access is pending
//   ReadDataM                  registered load result, valid in DONE
//   BusErr                     sticky timeout flag, cleared only by reset
//   mem_req/we/addr/be/wdata   registered request to data memory
//   mem_ack, mem_rdata         completion and read data from data memory
module mem_access_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemWriteM,
    input  logic [1:0]            ResultsrcM,
    input  logic                  ByteAddrM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic                  StallM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  BusErr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  req_q, req_d, we_q, we_d, err_q, err_d, bt_q, bt_d;
    logic [1:0]            off_q, off_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic                  access, timeout;
    logic [7:0]            lane;
    assign access  = MemWriteM | (ResultsrcM == 2'b01);
    assign timeout = cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    // offset and byte flag are latched with the request since the pipeline inputs may move in DONE
    assign lane    = mem_rdata[{off_q, 3'b000} +: 8];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        bt_d    = bt_q;
        off_d   = off_q;
        StallM  = 1'b0;
        case (state_q)
            IDLE: begin
                StallM = access;
                if (access) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = MemWriteM;
                    addr_d  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                    be_d    = ByteAddrM ? 4'b0001 << ALUResultM[1:0] : 4'b1111;
                    wdata_d = ByteAddrM ? {4{WriteDataM[7:0]}} : WriteDataM;
                    bt_d    = ByteAddrM;
                    off_d   = ALUResultM[1:0];
                end
            end
            REQ: begin
                StallM = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                // ack has priority over a coincident timeout
                if (mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = bt_q ? {{(DATA_WIDTH-8){1'b0}}, lane} : mem_rdata;
                end else if (timeout) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            bt_q    <= 1'b0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            bt_q    <= bt_d;
            off_q   <= off_d;
        end
    end
    assign ReadDataM = rdata_q;
    assign BusErr    = err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed table plus randomized transactions against a transaction-level model
module tb_mem_access_ctrl;
    localparam int TO = 16;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        MemWriteM = 1'b0, ByteAddrM = 1'b0, mem_ack = 1'b0;
    logic [1:0]  ResultsrcM = 2'b00;
    logic [31:0] ALUResultM = '0, WriteDataM = '0, mem_rdata = '0;
    logic        StallM, BusErr, mem_req, mem_we;
    logic [31:0] ReadDataM, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    int          n_pass = 0, n_total = 0;

    mem_access_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .MemWriteM(MemWriteM), .ResultsrcM(ResultsrcM),
        .ByteAddrM(ByteAddrM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataM(ReadDataM), .BusErr(BusErr), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  rs;
        logic        bt;
        logic [31:0] addr, wd, rd;
        int          ack_at;
        logic [3:0]  ebe;
        logic [31:0] eaddr, ewd, erd;
        logic        eerr;
        int          enreq;
    } vec_t;

    // Entered just after a posedge with the DUT in IDLE; returns just after a posedge back in IDLE.
    task automatic run_txn(input vec_t v);
        int n = 0, stalls = 0;
        MemWriteM = v.we; ResultsrcM = v.rs; ByteAddrM = v.bt;
        ALUResultM = v.addr; WriteDataM = v.wd; mem_ack = 1'b0;
        @(negedge clk);
        check("idle_req", {31'b0, mem_req}, 32'd0);
        stalls += int'(StallM);
        do begin
            @(posedge clk); #1;
            n++;
            mem_ack   = (n == v.ack_at);
            mem_rdata = (n == v.ack_at) ? v.rd : $urandom;
            @(negedge clk);
            stalls += int'(StallM);
            check("req_req",   {31'b0, mem_req}, 32'd1);
            check("req_we",    {31'b0, mem_we}, {31'b0, v.we});
            check("req_addr",  mem_addr, v.eaddr);
            check("req_be",    {28'b0, mem_be}, {28'b0, v.ebe});
            check("req_wdata", mem_wdata, v.ewd);
        end while (n != v.ack_at && n < TO);
        @(posedge clk); #1;
        mem_ack = 1'b0; MemWriteM = 1'b0; ResultsrcM = 2'b00;
        @(negedge clk);
        check("done_stall", {31'b0, StallM}, 32'd0);
        check("done_req",   {31'b0, mem_req}, 32'd0);
        check("done_rdata", ReadDataM, v.erd);
        check("done_err",   {31'b0, BusErr}, {31'b0, v.eerr});
        check("stall_cycles", stalls, v.enreq + 1);
        @(posedge clk); #1;
    endtask

    vec_t        tbl[5];
    vec_t        v;
    logic [31:0] rd_m;
    logic        err_m;
    logic [1:0]  off;

    initial begin
        //          we    rs     bt    addr          wdata         rdata         ack  be       eaddr         ewdata        erdata        err  nreq
        tbl[0] = '{1'b0, 2'b01, 1'b0, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 1, 4'hF,    32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 1'b0, 1};
        tbl[1] = '{1'b1, 2'b00, 1'b1, 32'h0000_0013, 32'h1234_56A5, 32'h5555_5555, 1, 4'b1000, 32'h0000_0010, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0, 1};
        tbl[2] = '{1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0,        32'h11C3_2233, 4, 4'b0100, 32'h0000_0200, 32'h0,        32'h0000_00C3, 1'b0, 4};
        tbl[3] = '{1'b0, 2'b01, 1'b0, 32'h0000_0043, 32'h0,        32'hCAFE_F00D, 16, 4'hF,   32'h0000_0040, 32'h0,        32'hCAFE_F00D, 1'b0, 16};
        tbl[4] = '{1'b0, 2'b01, 1'b0, 32'h0000_0080, 32'h0,        32'h0,         0, 4'hF,    32'h0000_0080, 32'h0,        32'h0,         1'b1, 16};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'b0, StallM}, 32'd0);
        check("rst_req",   {31'b0, mem_req}, 32'd0);
        check("rst_rdata", ReadDataM, 32'd0);
        check("rst_err",   {31'b0, BusErr}, 32'd0);
        check("rst_be",    {28'b0, mem_be}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) run_txn(tbl[i]);
        // BusErr remains set after the timeout while the pipeline idles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("err_sticky", {31'b0, BusErr}, 32'd1);
        // asynchronous reset in the middle of a request
        @(posedge clk); #1;
        MemWriteM = 1'b1; ByteAddrM = 1'b0; ALUResultM = 32'h0000_0300; WriteDataM = 32'h0BAD_F00D;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_req_before", {31'b0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0; MemWriteM = 1'b0;
        #1;
        check("t6_req",   {31'b0, mem_req}, 32'd0);
        check("t6_we",    {31'b0, mem_we}, 32'd0);
        check("t6_addr",  mem_addr, 32'd0);
        check("t6_be",    {28'b0, mem_be}, 32'd0);
        check("t6_wdata", mem_wdata, 32'd0);
        check("t6_rdata", ReadDataM, 32'd0);
        check("t6_err",   {31'b0, BusErr}, 32'd0);
        check("t6_stall", {31'b0, StallM}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // randomized transactions with a transaction-level model
        rd_m = '0; err_m = 1'b0;
        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 2)) begin
                MemWriteM = 1'b0;
                ResultsrcM = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10 | 2'($urandom_range(0, 1));
                ALUResultM = $urandom; mem_ack = 1'($urandom); mem_rdata = $urandom;
                @(negedge clk);
                check("gap_stall", {31'b0, StallM}, 32'd0);
                check("gap_rdata", ReadDataM, rd_m);
                @(posedge clk); #1;
                @(negedge clk);
                check("gap_req", {31'b0, mem_req}, 32'd0);
                @(posedge clk); #1;
            end
            mem_ack = 1'b0;
            v.we = 1'($urandom);
            v.rs = v.we ? 2'($urandom) : 2'b01;
            v.bt = 1'($urandom);
            v.addr = $urandom; v.wd = $urandom; v.rd = $urandom;
            v.ack_at = $urandom_range(1, 20);
            off = v.addr[1:0];
            v.ebe = v.bt ? 4'(1 << off) : 4'hF;
            v.eaddr = v.addr & 32'hFFFF_FFFC;
            v.ewd = v.bt ? {4{v.wd[7:0]}} : v.wd;
            v.enreq = (v.ack_at <= TO) ? v.ack_at : TO;
            if (v.ack_at > TO) begin
                rd_m = '0; err_m = 1'b1;
            end else if (!v.we) begin
                rd_m = v.bt ? (v.rd >> (8 * off)) & 32'hFF : v.rd;
            end
            v.erd = rd_m; v.eerr = err_m;
            run_txn(v);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
